// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Expands one 512-bit padded SHA-256 block, received as 16 big-endian
// 32-bit words, into the 64 schedule words W_0..W_63. Each word is emitted
// through a valid/ready output register together with its round index and,
// optionally, the round constant K_t.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   qualifies in_data
//   in_ready   high while a block word can be accepted (LOAD state)
//   in_data    one block word, M0 first
//   w_valid    qualifies w_out, k_out, round_idx and w_last
//   w_ready    consumer accepts the current word
//   w_out      schedule word W_t
//   k_out      round constant K_t (0 when the ROM is not built)
//   round_idx  t
//   w_last     high with t = 63
//
// Configuration
//   SHA256_SCHED_KROM_EN  when defined, an internal 64-entry ROM drives
//                         k_out = K_t; otherwise k_out is tied to 0 and the
//                         consumer looks K up from round_idx.
module sha256_msg_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic [5:0]  round_idx,
  output logic        w_last
);

  typedef enum logic {LOAD, GEN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic [5:0]  t_q, t_d;
  // Set once W_63 sits in the output register; t itself stays at 63.
  logic        done_q, done_d;
  logic        w_valid_q, w_valid_d;
  logic [31:0] w_out_q, w_out_d;
  logic [31:0] k_q, k_d;
  logic [5:0]  idx_q, idx_d;
  logic        last_q, last_d;

  // 16-entry circular buffer; slot t mod 16 holds the most recent W with
  // that residue. Data only, so it carries no reset.
  logic [31:0] sched_q [16];
  logic        sched_we;
  logic [3:0]  sched_waddr;
  logic [31:0] sched_wdata;

  logic [5:0]  emit_idx;
  logic [3:0]  slot;
  logic [31:0] w_new;
  logic [31:0] w_t;
  logic [31:0] k_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA256_SCHED_KROM_EN
  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign k_t = KROM[emit_idx];
`else
  assign k_t = 32'd0;
`endif

  // W_0 is emitted on the same edge that accepts the 16th input word, so
  // the index presented to the word generator is 0 while loading.
  assign emit_idx = (state_q == LOAD) ? 6'd0 : t_q;
  assign slot     = emit_idx[3:0];

  // (t-16) mod 16 == t mod 16, so the W[t-16] operand is the slot being
  // overwritten.
  assign w_new = sig1(sched_q[slot - 4'd2]) + sched_q[slot - 4'd7]
               + sig0(sched_q[slot - 4'd15]) + sched_q[slot];
  assign w_t   = (emit_idx < 6'd16) ? sched_q[slot] : w_new;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    t_d         = t_q;
    done_d      = done_q;
    w_valid_d   = w_valid_q;
    w_out_d     = w_out_q;
    k_d         = k_q;
    idx_d       = idx_q;
    last_d      = last_q;
    sched_we    = 1'b0;
    sched_waddr = load_cnt_q;
    sched_wdata = in_data;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          sched_we   = 1'b1;
          load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            // buffer[0] was written on the first beat, so W_0 is ready now
            state_d   = GEN;
            w_valid_d = 1'b1;
            w_out_d   = w_t;
            k_d       = k_t;
            idx_d     = 6'd0;
            last_d    = 1'b0;
            t_d       = 6'd1;
            done_d    = 1'b0;
          end
        end
      end
      GEN: begin
        if (done_q) begin
          // W_63 is held until accepted, then the block is finished
          if (w_ready) begin
            w_valid_d  = 1'b0;
            state_d    = LOAD;
            load_cnt_d = 4'd0;
            t_d        = 6'd0;
            done_d     = 1'b0;
          end
        end else if (!w_valid_q || w_ready) begin
          w_valid_d = 1'b1;
          w_out_d   = w_t;
          k_d       = k_t;
          idx_d     = t_q;
          last_d    = (t_q == 6'd63);
          if (t_q >= 6'd16) begin
            sched_we    = 1'b1;
            sched_waddr = slot;
            sched_wdata = w_new;
          end
          if (t_q == 6'd63) done_d = 1'b1;
          else              t_d    = t_q + 6'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // ---- control / output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= 4'd0;
      t_q        <= 6'd0;
      done_q     <= 1'b0;
      w_valid_q  <= 1'b0;
      w_out_q    <= 32'd0;
      k_q        <= 32'd0;
      idx_q      <= 6'd0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      done_q     <= done_d;
      w_valid_q  <= w_valid_d;
      w_out_q    <= w_out_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
    end
  end

  // ---- schedule buffer ----
  always_ff @(posedge clk) begin
    if (!rst && sched_we) sched_q[sched_waddr] <= sched_wdata;
  end

  assign in_ready  = (state_q == LOAD);
  assign w_valid   = w_valid_q;
  assign w_out     = w_out_q;
  assign k_out     = k_q;
  assign round_idx = idx_q;
  assign w_last    = last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic [5:0]  round_idx;
  logic        w_last;

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .k_out     (k_out),
    .round_idx (round_idx),
    .w_last    (w_last)
  );

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
    logic        kchk;
    logic [31:0] k;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Full linear 64-word expansion; for the "abc" block W16/W17 are replaced
  // by hand-derived constants.
  task automatic push_block(input logic [31:0] blk [16], input bit is_abc);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
    if (is_abc) begin
      w[16] = 32'h61626380;
      w[17] = 32'h000F0000;
    end
    for (int i = 0; i < 64; i++) begin
      e.w    = w[i];
      e.idx  = 6'(i);
      e.last = (i == 63);
`ifdef SHA256_SCHED_KROM_EN
      e.kchk = (i == 0) || (i == 63);
      e.k    = (i == 0) ? 32'h428a2f98 : 32'hc67178f2;
`else
      e.kchk = 1'b1;
      e.k    = 32'd0;
`endif
      sbq.push_back(e);
    end
  endtask

  // Monitor: every output handshake pops one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && w_valid === 1'b1 && w_ready === 1'b1) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got t=%0d w=%h, required no output", round_idx, w_out);
        end else begin
          e = sbq.pop_front();
          if (w_out !== e.w || round_idx !== e.idx || w_last !== e.last ||
              (e.kchk && k_out !== e.k)) begin
            n_fail++;
            $display("FAIL word: got t=%0d w=%h k=%h last=%b, required t=%0d w=%h k=%h last=%b",
                     round_idx, w_out, k_out, w_last, e.idx, e.w, e.k, e.last);
          end
        end
      end
    end
  end

  task automatic load_block(input logic [31:0] blk [16]);
    chk("in_ready_load", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("w0_latency", {24'd0, w_valid, in_ready, round_idx}, {24'd0, 1'b1, 1'b0, 6'd0});
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!(w_valid && w_last && w_ready) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got no w_last within 200 cycles, required w_last");
    end else begin
      @(posedge clk); #1;
      chk("after_last", {30'd0, w_valid, in_ready}, 32'd1);
    end
  endtask

  task automatic wait_idx(input logic [5:0] n);
    int cyc = 0;
    while (!(w_valid && round_idx == n) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idx_timeout: got no t=%0d within 200 cycles, required t=%0d", n, n);
    end
  endtask

  logic [31:0] blk [16];
  logic [31:0] hold_w, hold_k;
  logic [5:0]  hold_i;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;
    w_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {29'd0, w_valid, in_ready, w_last}, 32'd2);
    chk("reset_idx",  {26'd0, round_idx}, 32'd0);
    chk("reset_w",    w_out, 32'd0);
    chk("reset_k",    k_out, 32'd0);
    rst = 1'b0;

    // "abc" block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    push_block(blk, 1'b1);
    load_block(blk);
    wait_done();

    // back-to-back second block, with a 5-cycle stall at t=20
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    push_block(blk, 1'b0);
    load_block(blk);
    wait_idx(6'd20);
    w_ready = 1'b0;
    hold_w = w_out;
    hold_k = k_out;
    hold_i = round_idx;
    chk("stall_start_idx", {26'd0, hold_i}, 32'd20);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_w",   w_out, hold_w);
      chk("stall_k",   k_out, hold_k);
      chk("stall_idx", {25'd0, w_valid, round_idx}, {25'd0, 1'b1, 6'd20});
    end
    w_ready = 1'b1;
    wait_done();

    // garbage on the input during generation
    for (int i = 0; i < 16; i++) blk[i] = (32'(i) * 32'h01010101) ^ 32'hdeadbeef;
    push_block(blk, 1'b0);
    load_block(blk);
    repeat (10) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      chk("gen_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    wait_done();

    // reset in the middle of a block
    for (int i = 0; i < 16; i++) blk[i] = 32'hffffffff - 32'(i);
    push_block(blk, 1'b0);
    load_block(blk);
    wait_idx(6'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("post_reset", {24'd0, w_valid, in_ready, round_idx}, {24'd0, 1'b0, 1'b1, 6'd0});

    // fresh block after the reset
    for (int i = 0; i < 16; i++) blk[i] = 32'h13579bdf + 32'(i) * 32'h11111111;
    push_block(blk, 1'b0);
    load_block(blk);
    wait_done();

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
